// File: rtl/mem_stage_sram.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_sram
// Description : MEM stage with a 16-bit asynchronous SRAM data port; each
//               32-bit word is moved as two half-word phases while the
//               pipeline is frozen.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_sram #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en_in,
  input  logic                   mem_r_en_in,
  input  logic                   mem_w_en_in,
  input  logic [31:0]            alu_res_in,
  input  logic [31:0]            val_rm_in,
  input  logic [3:0]             dest_in,
  output logic                   wb_en_out,
  output logic                   mem_r_en_out,
  output logic [31:0]            alu_res_out,
  output logic [31:0]            mem_data_out,
  output logic [3:0]             dest_out,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in
);

  localparam int c_cnt_w  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int c_waddr_w = SRAM_ADDR_W - 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W_LO = 3'd1,
    W_HI = 3'd2,
    R_LO = 3'd3,
    R_HI = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_wait_cnt;
  logic [c_waddr_w-1:0] w_waddr;
  logic                 w_phase_end;

  // Byte offset from the SRAM window base, reduced to a 32-bit word index.
  assign w_waddr     = c_waddr_w'((alu_res_in - 32'(ADDR_BASE)) >> 2);
  assign w_phase_end = (r_wait_cnt == c_cnt_last);

  assign ready        = ((r_state == IDLE) && !mem_r_en_in && !mem_w_en_in) ||
                        (r_state == DONE);
  assign wb_en_out    = wb_en_in & ready;
  assign mem_r_en_out = mem_r_en_in & ready;
  assign alu_res_out  = alu_res_in;
  assign dest_out     = dest_in;

  // SRAM pins are loaded on the edge that enters each phase, so they are
  // valid for the whole phase and glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      mem_data_out <= '0;
      sram_we_n    <= 1'b1;
      sram_dq_oe   <= 1'b0;
      sram_addr    <= '0;
      sram_dq_out  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_w_en_in) begin
            r_state     <= W_LO;
            r_wait_cnt  <= '0;
            sram_addr   <= {w_waddr, 1'b0};
            sram_dq_out <= val_rm_in[15:0];
            sram_we_n   <= 1'b0;
            sram_dq_oe  <= 1'b1;
          end else if (mem_r_en_in) begin
            r_state    <= R_LO;
            r_wait_cnt <= '0;
            sram_addr  <= {w_waddr, 1'b0};
          end
        end
        W_LO: begin
          if (w_phase_end) begin
            r_state     <= W_HI;
            r_wait_cnt  <= '0;
            sram_addr   <= {w_waddr, 1'b1};
            sram_dq_out <= val_rm_in[31:16];
          end else begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
          end
        end
        W_HI: begin
          if (w_phase_end) begin
            r_state     <= DONE;
            r_wait_cnt  <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
          end
        end
        R_LO: begin
          if (w_phase_end) begin
            r_state            <= R_HI;
            r_wait_cnt         <= '0;
            mem_data_out[15:0] <= sram_dq_in;
            sram_addr          <= {w_waddr, 1'b1};
          end else begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
          end
        end
        R_HI: begin
          if (w_phase_end) begin
            r_state             <= DONE;
            r_wait_cnt          <= '0;
            mem_data_out[31:16] <= sram_dq_in;
            sram_addr           <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_sram
// Description : Directed bench for mem_stage_sram with a cycle-count model
//               and a small SRAM array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_sram;

  localparam int WAIT_CYCLES = 2;
  localparam int ADDR_BASE   = 1024;
  localparam int SRAM_ADDR_W = 18;
  localparam int LAST        = 2 * WAIT_CYCLES + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
  logic [31:0] alu_res_in = '0, val_rm_in = '0;
  logic [3:0]  dest_in = '0;
  logic        wb_en_out, mem_r_en_out, ready, sram_we_n, sram_dq_oe;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0]  dest_out;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  logic [15:0] sram [0:63];
  logic [15:0] mm   [0:63];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_stage_sram #(.WAIT_CYCLES(WAIT_CYCLES), .ADDR_BASE(ADDR_BASE), .SRAM_ADDR_W(SRAM_ADDR_W)) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
    .dest_in(dest_in), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .mem_data_out(mem_data_out), .dest_out(dest_out),
    .ready(ready), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  // Asynchronous SRAM: combinational read, write committed on each clocked write cycle.
  assign sram_dq_in = sram[sram_addr[5:0]];
  always @(posedge clk) if (!rst && !sram_we_n) sram[sram_addr[5:0]] <= sram_dq_out;

  // Model: mk counts cycles since the request cycle (0 = idle or request cycle).
  int          mk = 0;
  logic        mwr = 1'b0;
  logic [16:0] mwa = '0;
  logic [31:0] mdata = '0;
  logic [5:0]  lo_i, hi_i;
  assign lo_i = {mwa[4:0], 1'b0};
  assign hi_i = {mwa[4:0], 1'b1};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mk    <= 0;
      mdata <= '0;
    end else if (mk == 0) begin
      if (mem_w_en_in || mem_r_en_in) begin
        mk  <= 1;
        mwr <= mem_w_en_in;
        mwa <= 17'((alu_res_in - ADDR_BASE) >> 2);
        if (mem_w_en_in) begin
          mm[{alu_res_in[6:2] - 5'd0, 1'b0}] <= val_rm_in[15:0];
          mm[{alu_res_in[6:2] - 5'd0, 1'b1}] <= val_rm_in[31:16];
        end
      end
    end else if (mk == LAST) begin
      mk <= 0;
    end else begin
      if (!mwr && mk == WAIT_CYCLES)     mdata[15:0]  <= mm[lo_i];
      if (!mwr && mk == 2 * WAIT_CYCLES) mdata[31:16] <= mm[hi_i];
      mk <= mk + 1;
    end
  end

  logic        e_ready, e_phase, e_hi, e_wr;
  logic [31:0] e_dq, e_addr;
  assign e_ready = (mk == 0) ? !(mem_r_en_in || mem_w_en_in) : (mk == LAST);
  assign e_phase = (mk >= 1) && (mk <= 2 * WAIT_CYCLES);
  assign e_hi    = (mk > WAIT_CYCLES);
  assign e_wr    = mwr && e_phase;
  assign e_dq    = e_wr ? (e_hi ? {16'h0, val_rm_in[31:16]} : {16'h0, val_rm_in[15:0]}) : 32'h0;
  assign e_addr  = {14'h0, mwa, e_hi};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_ready", {31'h0, ready}, {31'h0, e_ready});
      chk("m_wb_en_out", {31'h0, wb_en_out}, {31'h0, wb_en_in & e_ready});
      chk("m_mem_r_en_out", {31'h0, mem_r_en_out}, {31'h0, mem_r_en_in & e_ready});
      chk("m_alu_res_out", alu_res_out, alu_res_in);
      chk("m_dest_out", {28'h0, dest_out}, {28'h0, dest_in});
      chk("m_mem_data_out", mem_data_out, mdata);
      chk("m_sram_we_n", {31'h0, sram_we_n}, {31'h0, !e_wr});
      chk("m_sram_dq_oe", {31'h0, sram_dq_oe}, {31'h0, e_wr});
      chk("m_sram_dq_out", {16'h0, sram_dq_out}, e_dq);
      if (e_phase) chk("m_sram_addr", {14'h0, sram_addr}, e_addr);
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the cycle where ready rises; stall = cycles with ready low.
  task automatic wait_ready(output int stall);
    stall = 0;
    @(negedge clk);
    while (!ready && stall < 20) begin
      stall++;
      @(negedge clk);
    end
    if (stall >= 20) chk("ready_timeout", 32'(stall), 32'd0);
  endtask

  task automatic set_in(input logic w, input logic r, input logic wb,
                        input logic [31:0] a, input logic [31:0] v, input logic [3:0] d);
    mem_w_en_in = w; mem_r_en_in = r; wb_en_in = wb;
    alu_res_in = a; val_rm_in = v; dest_in = d;
  endtask

  initial begin
    int st;
    for (int i = 0; i < 64; i++) begin
      sram[i] = 16'h1000 + 16'(i);
      mm[i]   = 16'h1000 + 16'(i);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'd1);
    chk("rst_we_n", {31'h0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'h0, sram_dq_oe}, 32'd0);
    chk("rst_mem_data", mem_data_out, 32'd0);

    // Store 0xDEADBEEF to byte 1032 -> half-words 4/5
    adv();
    set_in(1'b1, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd2);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      chk("st_ready", {31'h0, ready}, (c <= 4) ? 32'd0 : 32'd1);
      if (c == 0) chk("st_wb_en_out", {31'h0, wb_en_out}, 32'd0);
      if (c == 1 || c == 2) begin
        chk("st_addr_lo", {14'h0, sram_addr}, 32'd4);
        chk("st_dq_lo", {16'h0, sram_dq_out}, 32'h0000BEEF);
        chk("st_we_n_lo", {31'h0, sram_we_n}, 32'd0);
      end
      if (c == 3 || c == 4) begin
        chk("st_addr_hi", {14'h0, sram_addr}, 32'd5);
        chk("st_dq_hi", {16'h0, sram_dq_out}, 32'h0000DEAD);
      end
      if (c < 5) adv();
    end
    adv();

    // Load back from 1032
    set_in(1'b0, 1'b1, 1'b1, 32'd1032, 32'h0, 4'd5);
    wait_ready(st);
    chk("ld_stall", 32'(st), 32'd5);
    chk("ld_data", mem_data_out, 32'hDEADBEEF);
    chk("ld_mem_r_en_out", {31'h0, mem_r_en_out}, 32'd1);
    adv();

    // Plain ALU op: no stall
    set_in(1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 4'd3);
    #1;
    chk("alu_ready", {31'h0, ready}, 32'd1);
    chk("alu_wb_en_out", {31'h0, wb_en_out}, 32'd1);
    chk("alu_res_out", alu_res_out, 32'h55);
    chk("alu_dest_out", {28'h0, dest_out}, 32'd3);
    chk("alu_we_n", {31'h0, sram_we_n}, 32'd1);
    adv();

    // Both enables: write only, read data unchanged
    set_in(1'b1, 1'b1, 1'b0, 32'd1040, 32'h12345678, 4'd1);
    wait_ready(st);
    chk("both_stall", 32'(st), 32'd5);
    chk("both_mem_data", mem_data_out, 32'hDEADBEEF);
    adv();

    // Back-to-back loads
    set_in(1'b0, 1'b1, 1'b1, 32'd1040, 32'h0, 4'd6);
    wait_ready(st);
    chk("b2b1_stall", 32'(st), 32'd5);
    chk("b2b1_data", mem_data_out, 32'h12345678);
    adv();
    set_in(1'b0, 1'b1, 1'b1, 32'd1044, 32'h0, 4'd7);
    wait_ready(st);
    chk("b2b2_stall", 32'(st), 32'd5);
    chk("b2b2_data", mem_data_out, 32'h100B100A);
    adv();

    // Reset asserted in the middle of W_HI
    set_in(1'b1, 1'b0, 1'b0, 32'd1048, 32'hCAFEF00D, 4'd0);
    repeat (3) adv();
    @(negedge clk);
    chk("rsthi_we_n_before", {31'h0, sram_we_n}, 32'd0);
    chk("rsthi_addr_before", {14'h0, sram_addr}, 32'd13);
    #2 rst = 1'b1;
    #1;
    chk("rsthi_we_n", {31'h0, sram_we_n}, 32'd1);
    chk("rsthi_oe", {31'h0, sram_dq_oe}, 32'd0);
    chk("rsthi_mem_data", mem_data_out, 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("rsthi_ready_after", {31'h0, ready}, 32'd1);
    repeat (3) adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register outputs: WB_EN, MEM_R_EN, MEM_W_EN, ALU result, valRm, dest.
- Performs the data-memory access against an external 16-bit asynchronous SRAM, two half-word accesses per 32-bit word.
- Drives a `ready` freeze signal that stalls the pipeline while an access is in flight.
- Forwards WB_EN, MEM_R_EN, ALU result, read data and dest to the MEM/WB register.

Parameters:
- WAIT_CYCLES, 2, cycles each half-word address/data phase is held (≥1).
- ADDR_BASE, 1024, byte address mapped to SRAM word 0.
- SRAM_ADDR_W, 18, SRAM address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- wb_en_in  in  1  write-back enable from EXE/MEM register.
- mem_r_en_in  in  1  load request.
- mem_w_en_in  in  1  store request.
- alu_res_in  in  32  byte address for memory ops; pass-through value otherwise.
- val_rm_in  in  32  store data.
- dest_in  in  4  destination register.
- wb_en_out  out  1  to MEM/WB register; 0 when ready=0.
- mem_r_en_out  out  1  to MEM/WB register; 0 when ready=0.
- alu_res_out  out  32  equals alu_res_in.
- mem_data_out  out  32  registered read data.
- dest_out  out  4  equals dest_in.
- ready  out  1  1 = pipeline may advance; 0 = freeze all pipeline registers and PC.
- sram_addr  out  SRAM_ADDR_W  SRAM half-word address.
- sram_we_n  out  1  active-low write strobe.
- sram_dq_out  out  16  write data.
- sram_dq_oe  out  1  1 = controller drives the data bus.
- sram_dq_in  in  16  read data from SRAM.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, wait counter=0, mem_data_out=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- Word address: waddr = (alu_res_in − ADDR_BASE) >> 2, mod 32-bit subtraction, truncated to SRAM_ADDR_W−1 bits.
- Half-word addresses: low half at {waddr,0}, high half at {waddr,1}.
- States: IDLE, W_LO, W_HI, R_LO, R_HI, DONE.
- IDLE:
  - mem_w_en_in=1 → W_LO. Write has priority if both enables are 1; no read is performed and mem_data_out is unchanged.
  - Else mem_r_en_in=1 → R_LO.
  - Else stay in IDLE.
- Each LO/HI state lasts exactly WAIT_CYCLES cycles, counted by a counter cleared on state entry.
- Write phases:
  - W_LO: sram_addr={waddr,0}, sram_dq_out=val_rm_in[15:0], sram_we_n=0, sram_dq_oe=1; then W_HI.
  - W_HI: sram_addr={waddr,1}, sram_dq_out=val_rm_in[31:16], sram_we_n=0, sram_dq_oe=1; then DONE.
- Read phases:
  - R_LO: sram_addr={waddr,0}, sram_we_n=1, sram_dq_oe=0; on its last cycle, register sram_dq_in into mem_data_out[15:0]; then R_HI.
  - R_HI: sram_addr={waddr,1}; on its last cycle, register sram_dq_in into mem_data_out[31:16]; then DONE.
- DONE: one cycle, sram_we_n=1, sram_dq_oe=0; then IDLE unconditionally, even if the inputs still show a request.
- ready (combinational) = (state==IDLE && !mem_r_en_in && !mem_w_en_in) || state==DONE.
  - Inputs are held stable by the freeze while ready=0.
- Latency:
  - A memory op holds ready=0 for 2·WAIT_CYCLES+1 cycles, counting the IDLE request cycle.
  - ready=1 in DONE, when the pipeline advances.
  - Non-memory ops: zero stall.
- Pass-through outputs: alu_res_out and dest_out are combinational from their inputs. wb_en_out and mem_r_en_out are gated by ready.
- Reset mid-operation:
  - FSM returns to IDLE asynchronously; sram_we_n rises immediately.
  - A partially written word is not completed.
  - mem_data_out clears to 0.
- Outside write states, sram_dq_out=0 and sram_dq_oe=0.

Test Plan:
- Configuration for all scenarios: WAIT_CYCLES=2, ADDR_BASE=1024.
- Reset, no request → ready=1, sram_we_n=1, sram_dq_oe=0, mem_data_out=0.
- Store, alu_res_in=1032, val_rm_in=0xDEADBEEF at cycle 0:
  - cycles 1–2: sram_addr=4, sram_dq_out=0xBEEF, sram_we_n=0.
  - cycles 3–4: sram_addr=5, sram_dq_out=0xDEAD.
  - ready=0 in cycles 0–4 and 1 in cycle 5; wb_en_out=0 while stalled.
- Load, alu_res_in=1032, SRAM model returns 0xBEEF@4 and 0xDEAD@5 → in DONE: mem_data_out=0xDEADBEEF, mem_r_en_out=1, ready=1.
- ALU op (no mem enables), wb_en_in=1, alu_res_in=0x55, dest_in=3 → same cycle: ready=1, wb_en_out=1, alu_res_out=0x55, dest_out=3; SRAM idle.
- rst pulsed mid-W_HI → sram_we_n=1 and sram_dq_oe=0 without waiting for a clock edge; after release with no request, ready=1.
- mem_r_en_in=mem_w_en_in=1 → write sequence only, sram_we_n=0 during both phases, mem_data_out unchanged; back-to-back loads each stall 5 cycles.
